key_schedule_seq: RTL and testbench

KEY_SCHEDULE_SEQ -- requirements
Module: key_schedule_seq

---
 rtl/key_schedule_seq.sv | 143 ++++++++++++++
 tb/tb_key_schedule_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_seq.sv
// Sequential S-AES style key schedule: emits NUM_ROUNDS+1 round keys over a valid/ready handshake.
// Optional KS_READBACK_EN adds a per-round key store readable through Rd_Addr/Rd_Key.
module key_schedule_seq #(
   parameter int NUM_ROUNDS = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        Start,
   input  logic [15:0] Key,
   output logic        Key_Valid,
   input  logic        Key_Ready,
   output logic [15:0] Round_Key,
   output logic [2:0]  Round_Idx,
   output logic        Busy,
   output logic        Done
`ifdef KS_READBACK_EN
   ,
   input  logic [2:0]  Rd_Addr,
   output logic [15:0] Rd_Key
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EMIT,
      ST_DONE
   } state_t;

   localparam logic [2:0] LAST_IDX  = 3'(NUM_ROUNDS);
   localparam logic [3:0] RCON_INIT = 4'h8;

   state_t      state_q, state_d;
   logic [3:0]  rcon_q;
   logic [15:0] next_key;
   logic        start_accept;
   logic        transfer;
   logic        last_round;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h9;  4'h1: y = 4'h4;  4'h2: y = 4'hA;  4'h3: y = 4'hB;
         4'h4: y = 4'hD;  4'h5: y = 4'h1;  4'h6: y = 4'h8;  4'h7: y = 4'h5;
         4'h8: y = 4'h6;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'h3;
         4'hC: y = 4'hC;  4'hD: y = 4'hE;  4'hE: y = 4'hF;  default: y = 4'h7;
      endcase
      return y;
   endfunction

   // Multiply by x in GF(2^4) modulo x^4+x+1.
   function automatic logic [3:0] xtime(input logic [3:0] r);
      return {r[2:0], 1'b0} ^ (r[3] ? 4'h3 : 4'h0);
   endfunction

   assign start_accept = (state_q == ST_IDLE) && Start;
   assign transfer     = (state_q == ST_EMIT) && Key_Ready;
   assign last_round   = (Round_Idx == LAST_IDX);

   always_comb begin
      logic [7:0] w0, w1, w2, w3, g;
      w0       = Round_Key[15:8];
      w1       = Round_Key[7:0];
      g        = {sbox(w1[3:0]), sbox(w1[7:4])} ^ {rcon_q, 4'h0};
      w2       = w0 ^ g;
      w3       = w2 ^ w1;
      next_key = {w2, w3};
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (Start) state_d = ST_EMIT;
         ST_EMIT: if (Key_Ready && last_round) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      Key_Valid = 1'b0;
      Busy      = 1'b0;
      Done      = 1'b0;
      case (state_q)
         ST_EMIT: begin
            Key_Valid = 1'b1;
            Busy      = 1'b1;
         end
         ST_DONE: begin
            Busy = 1'b1;
            Done = 1'b1;
         end
         default: ;
      endcase
   end

   // Round key, index and RCON hold their values except on load or a non-final transfer.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         Round_Key <= 16'h0000;
         Round_Idx <= 3'd0;
         rcon_q    <= RCON_INIT;
      end else if (start_accept) begin
         Round_Key <= Key;
         Round_Idx <= 3'd0;
         rcon_q    <= RCON_INIT;
      end else if (transfer && !last_round) begin
         Round_Key <= next_key;
         Round_Idx <= Round_Idx + 3'd1;
         rcon_q    <= xtime(rcon_q);
      end
   end

`ifdef KS_READBACK_EN
   logic [15:0] store [NUM_ROUNDS+1];

   // NOTE: this store is a handful of flops, so it takes the async reset like any other state.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i <= NUM_ROUNDS; i++) store[i] <= 16'h0000;
      end else if (start_accept) begin
         for (int i = 0; i <= NUM_ROUNDS; i++) store[i] <= 16'h0000;
      end else if (transfer) begin
         for (int i = 0; i <= NUM_ROUNDS; i++)
            if (Round_Idx == 3'(i)) store[i] <= Round_Key;
      end
   end

   // Addresses past the last round fall through to zero.
   always_comb begin
      Rd_Key = 16'h0000;
      for (int i = 0; i <= NUM_ROUNDS; i++)
         if (Rd_Addr == 3'(i)) Rd_Key = store[i];
   end
`endif

endmodule

// File: tb/tb_key_schedule_seq.sv
// Directed bench for key_schedule_seq: NUM_ROUNDS=2 and NUM_ROUNDS=3 instances, table-driven cycles
// plus hand-written reset, stall and readback (KS_READBACK_EN) sequences.
module tb_key_schedule_seq;

   logic        clk;
   logic        rst;
   logic        start2, start3;
   logic [15:0] key;
   logic        key_ready;

   logic        valid2, busy2, done2;
   logic [15:0] rkey2;
   logic [2:0]  idx2;
   logic        valid3, busy3, done3;
   logic [15:0] rkey3;
   logic [2:0]  idx3;
`ifdef KS_READBACK_EN
   logic [2:0]  rd_addr2, rd_addr3;
   logic [15:0] rd_key2, rd_key3;
`endif

   int n_checks = 0;
   int n_err    = 0;

   key_schedule_seq #(.NUM_ROUNDS(2)) dut2 (
      .CLK(clk), .RST(rst), .Start(start2), .Key(key), .Key_Valid(valid2), .Key_Ready(key_ready),
      .Round_Key(rkey2), .Round_Idx(idx2), .Busy(busy2), .Done(done2)
`ifdef KS_READBACK_EN
      , .Rd_Addr(rd_addr2), .Rd_Key(rd_key2)
`endif
   );

   key_schedule_seq #(.NUM_ROUNDS(3)) dut3 (
      .CLK(clk), .RST(rst), .Start(start3), .Key(key), .Key_Valid(valid3), .Key_Ready(key_ready),
      .Round_Key(rkey3), .Round_Idx(idx3), .Busy(busy3), .Done(done3)
`ifdef KS_READBACK_EN
      , .Rd_Addr(rd_addr3), .Rd_Key(rd_key3)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        start;
      logic [15:0] key;
      logic        ready;
      logic        exp_valid;
      logic [15:0] exp_key;
      logic [2:0]  exp_idx;
      logic        exp_done;
      logic        exp_busy;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic s, input logic [15:0] k, input logic r, input logic v,
                      input logic [15:0] ek, input logic [2:0] ei, input logic d, input logic b);
      vec_t t;
      t.start = s; t.key = k; t.ready = r; t.exp_valid = v;
      t.exp_key = ek; t.exp_idx = ei; t.exp_done = d; t.exp_busy = b;
      vecs.push_back(t);
   endtask

   // Each row: at the falling edge, compare dut2 outputs, then drive inputs for the next rising edge.
   task automatic apply_vecs(input string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         check($sformatf("%s[%0d] valid", tag, i), 32'(valid2), 32'(vecs[i].exp_valid));
         check($sformatf("%s[%0d] key",   tag, i), 32'(rkey2),  32'(vecs[i].exp_key));
         check($sformatf("%s[%0d] idx",   tag, i), 32'(idx2),   32'(vecs[i].exp_idx));
         check($sformatf("%s[%0d] done",  tag, i), 32'(done2),  32'(vecs[i].exp_done));
         check($sformatf("%s[%0d] busy",  tag, i), 32'(busy2),  32'(vecs[i].exp_busy));
         start2    = vecs[i].start;
         key       = vecs[i].key;
         key_ready = vecs[i].ready;
      end
      start2 = 1'b0;
   endtask

   task automatic kick2(input logic [15:0] k);
      @(negedge clk);
      start2    = 1'b1;
      key       = k;
      key_ready = 1'b1;
   endtask

   task automatic clean_run(input string tag);
      kick2(16'hA73B);
      vecs.delete();
      add(0, 16'h0000, 1, 1, 16'hA73B, 0, 0, 1);
      add(0, 16'h0000, 1, 1, 16'h1C27, 1, 0, 1);
      add(0, 16'h0000, 1, 1, 16'h7651, 2, 0, 1);
      add(0, 16'h0000, 1, 0, 16'h7651, 2, 1, 1);
      add(0, 16'h0000, 0, 0, 16'h7651, 2, 0, 0);
      apply_vecs(tag);
   endtask

   logic [15:0] exp3 [4];

   initial begin
      int  nxfer;
      bit  seen_done;

      rst = 1'b0; start2 = 1'b0; start3 = 1'b0; key = 16'h0000; key_ready = 1'b0;
`ifdef KS_READBACK_EN
      rd_addr2 = 3'd0; rd_addr3 = 3'd0;
`endif
      exp3[0] = 16'hA73B; exp3[1] = 16'h1C27; exp3[2] = 16'h7651; exp3[3] = 16'h5706;

      #12;
      check("reset valid", 32'(valid2), 32'h0);
      check("reset key",   32'(rkey2),  32'h0);
      check("reset idx",   32'(idx2),   32'h0);
      check("reset busy",  32'(busy2),  32'h0);
      check("reset done",  32'(done2),  32'h0);
      check("reset n3 busy", 32'(busy3), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      clean_run("basic");

      // Stall 5 cycles at idx 1, Start/Key noise in EMIT and a Start during DONE.
      kick2(16'hA73B);
      vecs.delete();
      add(1, 16'hFFFF, 1, 1, 16'hA73B, 0, 0, 1);
      add(1, 16'hFFFF, 0, 1, 16'h1C27, 1, 0, 1);
      add(1, 16'hFFFF, 0, 1, 16'h1C27, 1, 0, 1);
      add(1, 16'hFFFF, 0, 1, 16'h1C27, 1, 0, 1);
      add(1, 16'hFFFF, 0, 1, 16'h1C27, 1, 0, 1);
      add(1, 16'hFFFF, 0, 1, 16'h1C27, 1, 0, 1);
      add(0, 16'hA73B, 1, 1, 16'h1C27, 1, 0, 1);
      add(0, 16'hA73B, 1, 1, 16'h7651, 2, 0, 1);
      add(1, 16'hFFFF, 1, 0, 16'h7651, 2, 1, 1);
      add(0, 16'hFFFF, 1, 0, 16'h7651, 2, 0, 0);
      add(0, 16'hFFFF, 1, 0, 16'h7651, 2, 0, 0);
      apply_vecs("stall");

      // Reset mid-expansion at idx 1.
      kick2(16'hA73B);
      @(negedge clk);
      start2 = 1'b0;
      check("abort idx0 key", 32'(rkey2), 32'hA73B);
      @(negedge clk);
      key_ready = 1'b0;
      check("abort idx1 idx", 32'(idx2), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("abort valid", 32'(valid2), 32'h0);
      check("abort key",   32'(rkey2),  32'h0);
      check("abort idx",   32'(idx2),   32'h0);
      check("abort busy",  32'(busy2),  32'h0);
      check("abort done",  32'(done2),  32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("abort no done %0d", i), 32'(done2), 32'h0);
      end
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("post-reset idle %0d", i), 32'({valid2, busy2, done2}), 32'h0);
      end

      clean_run("rerun");

`ifdef KS_READBACK_EN
      rd_addr2 = 3'd0; #1 check("rd 0", 32'(rd_key2), 32'hA73B);
      rd_addr2 = 3'd1; #1 check("rd 1", 32'(rd_key2), 32'h1C27);
      rd_addr2 = 3'd2; #1 check("rd 2", 32'(rd_key2), 32'h7651);
      rd_addr2 = 3'd5; #1 check("rd 5", 32'(rd_key2), 32'h0000);
`endif

      // NUM_ROUNDS=3 instance: four keys, Busy held through DONE.
      @(negedge clk);
      start3 = 1'b1; key = 16'hA73B; key_ready = 1'b1;
      @(negedge clk);
      start3 = 1'b0;
      nxfer = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 20 && !seen_done; c++) begin
         check($sformatf("n3 busy c%0d", c), 32'(busy3), 32'h1);
         if (valid3 && nxfer < 4) begin
            check($sformatf("n3 key %0d", nxfer), 32'(rkey3), 32'(exp3[nxfer]));
            check($sformatf("n3 idx %0d", nxfer), 32'(idx3), 32'(nxfer));
            nxfer++;
         end
         if (done3) begin
            seen_done = 1'b1;
            check("n3 transfers before done", 32'(nxfer), 32'd4);
         end
         @(negedge clk);
      end
      check("n3 done seen", 32'(seen_done), 32'h1);
      check("n3 idle busy", 32'(busy3), 32'h0);
      check("n3 idle done", 32'(done3), 32'h0);
      check("n3 retained key", 32'(rkey3), 32'h5706);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
